// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
//   clr_state_t : bulk-clear sequencer states
//   addr_w()    : address width derived from the register count
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Register file access bus: two combinational read ports, one write port,
// bulk-clear request and busy status.
//   master : datapath side (drives addresses, write data, write, clear)
//   slave  : register file side (drives read data and busy)
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned AW = addr_w(DEPTH);

  logic [AW-1:0]    rdreg1;
  logic [AW-1:0]    rdreg2;
  logic [WIDTH-1:0] rdData1;
  logic [WIDTH-1:0] rdData2;
  logic [AW-1:0]    wrreg;
  logic [WIDTH-1:0] wrData;
  logic             write;
  logic             clear;
  logic             busy;

  modport master (
    output rdreg1, rdreg2, wrreg, wrData, write, clear,
    input  rdData1, rdData2, busy
  );

  modport slave (
    input  rdreg1, rdreg2, wrreg, wrData, write, clear,
    output rdData1, rdData2, busy
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer. On a clear request in IDLE it sweeps every address
// once, one per clock, then returns to IDLE. Requests during a sweep are
// ignored.
//   clock, reset : rising-edge clock, async active-high reset
//   clear        : clear request (pulse or level)
//   busy         : high while the sweep runs
//   clr_en       : zero the entry at clr_addr on this edge
//   clr_addr     : entry currently being cleared
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  output logic                     clr_en,
  output logic [addr_w(DEPTH)-1:0] clr_addr
);

  localparam int unsigned AW = addr_w(DEPTH);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_en   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register bank with two combinational read ports and one
// write port, optional hard-wired zero register, optional write-to-read
// bypass and a sequenced bulk-clear engine.
//   clock, reset : rising-edge clock, async active-high reset (zeros array)
//   bus (slave)  : rdreg1/rdreg2 -> rdData1/rdData2, wrreg/wrData/write,
//                  clear request, busy status
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic     clock,
  input  logic     reset,
  regfile_if.slave bus
);

  localparam int unsigned AW = addr_w(DEPTH);

  logic [WIDTH-1:0] bank [DEPTH];
  logic             busy;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok;
  logic [WIDTH-1:0] rd1, rd2;

  regfile_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clock    (clock),
    .reset    (reset),
    .clear    (bus.clear),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // A write is live only outside a sweep and when not aimed at a hard zero.
  // The same qualifier gates the bypass so forwarding never shows a value
  // that will not be stored.
  assign wr_ok = bus.write && !busy && !(ZERO_REG && (bus.wrreg == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else if (clr_en) begin
      bank[clr_addr] <= '0;
    end else if (wr_ok) begin
      bank[bus.wrreg] <= bus.wrData;
    end
  end

  always_comb begin
    rd1 = bank[bus.rdreg1];
    rd2 = bank[bus.rdreg2];
    if (BYPASS && wr_ok && (bus.wrreg == bus.rdreg1)) rd1 = bus.wrData;
    if (BYPASS && wr_ok && (bus.wrreg == bus.rdreg2)) rd2 = bus.wrData;
    if (ZERO_REG && (bus.rdreg1 == '0)) rd1 = '0;
    if (ZERO_REG && (bus.rdreg2 == '0)) rd2 = '0;
  end

  assign bus.rdData1 = rd1;
  assign bus.rdData2 = rd2;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT 0: DEPTH=8, no zero register, bypass on.
  // DUT 1: DEPTH=4, zero register, bypass off.
  regfile_if #(.WIDTH(32), .DEPTH(8)) ia ();
  regfile_if #(.WIDTH(32), .DEPTH(4)) ib ();

  regfile_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .clock(clock), .reset(reset), .bus(ia)
  );
  regfile_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset(reset), .bus(ib)
  );

  logic        t_wr [2];
  logic [2:0]  t_wa [2];
  logic [31:0] t_wd [2];
  logic        t_cl [2];
  logic [2:0]  t_r1 [2];
  logic [2:0]  t_r2 [2];

  assign ia.write  = t_wr[0];
  assign ia.wrreg  = t_wa[0];
  assign ia.wrData = t_wd[0];
  assign ia.clear  = t_cl[0];
  assign ia.rdreg1 = t_r1[0];
  assign ia.rdreg2 = t_r2[0];
  assign ib.write  = t_wr[1];
  assign ib.wrreg  = t_wa[1][1:0];
  assign ib.wrData = t_wd[1];
  assign ib.clear  = t_cl[1];
  assign ib.rdreg1 = t_r1[1][1:0];
  assign ib.rdreg2 = t_r2[1][1:0];

  // Reference model: register contents plus the index of the next entry the
  // sweep will clear (-1 when no sweep is running).
  logic [31:0] m [2][8];
  int          sw [2];
  int          dep [2] = '{8, 4};
  bit          zr  [2] = '{1'b0, 1'b1};
  bit          bp  [2] = '{1'b1, 1'b0};

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] act_rd(input int d, input int p);
    if (d == 0) return (p == 1) ? ia.rdData1 : ia.rdData2;
    return (p == 1) ? ib.rdData1 : ib.rdData2;
  endfunction

  function automatic logic act_busy(input int d);
    return (d == 0) ? ia.busy : ib.busy;
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [2:0] a);
    if (zr[d] && a == 3'd0) return 32'h0;
    if (bp[d] && sw[d] < 0 && t_wr[d] && t_wa[d] == a) return t_wd[d];
    return m[d][a];
  endfunction

  function automatic logic exp_busy(input int d);
    return sw[d] >= 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) m[d][a] = 32'h0;
      sw[d] = -1;
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      t_wr[d] = 1'b0; t_wa[d] = 3'd0; t_wd[d] = 32'h0;
      t_cl[d] = 1'b0; t_r1[d] = 3'd0; t_r2[d] = 3'd0;
    end
  endtask

  // One rising edge; the model consumes the inputs that were held across it.
  task automatic tick();
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (sw[d] >= 0) begin
        m[d][sw[d]] = 32'h0;
        sw[d]++;
        if (sw[d] == dep[d]) sw[d] = -1;
      end else begin
        if (t_wr[d] && !(zr[d] && t_wa[d] == 3'd0)) m[d][t_wa[d]] = t_wd[d];
        if (t_cl[d]) sw[d] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      t_wr[d] = 1'b1; t_wa[d] = 3'd1; t_wd[d] = $urandom | 32'h1;
    end
    tick();
    idle_inputs();
    #2 reset = 1'b1;
    #1 model_reset();
    for (int a = 0; a < 8; a++) begin
      for (int d = 0; d < 2; d++) begin
        t_r1[d] = 3'(a % dep[d]);
        t_r2[d] = 3'(a % dep[d]);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_rd(d, 1) !== 32'h0 || act_rd(d, 2) !== 32'h0 || act_busy(d) !== 1'b0) begin
          failures++;
          $display("FAIL reset d=%0d a=%0d rd1=%h rd2=%h busy=%b expected 0/0/0",
                   d, a, act_rd(d, 1), act_rd(d, 2), act_busy(d));
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    for (int d = 0; d < 2; d++) begin
      t_wr[d] = 1'b1; t_wa[d] = 3'd2; t_wd[d] = 32'hDEADBEEF;
      t_r1[d] = 3'd2; t_r2[d] = 3'd2;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== exp_rd(d, 3'd2) || act_rd(d, 2) !== exp_rd(d, 3'd2)) begin
        failures++;
        $display("FAIL same_cycle_read d=%0d rd1=%h rd2=%h expected %h",
                 d, act_rd(d, 1), act_rd(d, 2), exp_rd(d, 3'd2));
      end
    end
    tick();
    t_wr[0] = 1'b0; t_wr[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== 32'hDEADBEEF || act_rd(d, 2) !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL write_read d=%0d rd1=%h rd2=%h expected deadbeef",
                 d, act_rd(d, 1), act_rd(d, 2));
      end
    end
  endtask

  task automatic test_zero_reg();
    for (int d = 0; d < 2; d++) begin
      t_wr[d] = 1'b1; t_wa[d] = 3'd0; t_wd[d] = 32'h12345678;
      t_r1[d] = 3'd0; t_r2[d] = 3'd0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== exp_rd(d, 3'd0) || act_rd(d, 2) !== exp_rd(d, 3'd0)) begin
        failures++;
        $display("FAIL zero_reg_bypass d=%0d rd1=%h rd2=%h expected %h",
                 d, act_rd(d, 1), act_rd(d, 2), exp_rd(d, 3'd0));
      end
    end
    tick();
    t_wr[0] = 1'b0; t_wr[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== exp_rd(d, 3'd0)) begin
        failures++;
        $display("FAIL zero_reg d=%0d rd1=%h expected %h", d, act_rd(d, 1), exp_rd(d, 3'd0));
      end
    end
  endtask

  task automatic test_bulk_clear();
    int n;
    idle_inputs();
    for (int a = 0; a < 8; a++) begin
      t_wr[0] = 1'b1; t_wa[0] = 3'(a); t_wd[0] = 32'(a + 1);
      tick();
    end
    t_wr[0] = 1'b0;
    for (int a = 0; a < 8; a++) begin
      t_r1[0] = 3'(a);
      #1;
      checks++;
      if (act_rd(0, 1) !== 32'(a + 1)) begin
        failures++;
        $display("FAIL fill a=%0d rd1=%h expected %h", a, act_rd(0, 1), 32'(a + 1));
      end
    end
    t_cl[0] = 1'b1;
    tick();
    t_cl[0] = 1'b0;
    n = 0;
    while (act_busy(0) === 1'b1 && n < 20) begin
      t_wr[0] = (n == 2);
      t_wa[0] = 3'd5;
      t_wd[0] = 32'hAA;
      t_r1[0] = 3'd5;
      t_r2[0] = 3'(n % 8);
      #1;
      checks++;
      if (act_rd(0, 1) !== exp_rd(0, 3'd5) || act_rd(0, 2) !== exp_rd(0, t_r2[0])
          || act_busy(0) !== exp_busy(0)) begin
        failures++;
        $display("FAIL sweep n=%0d rd1=%h/%h rd2=%h/%h busy=%b/%b", n,
                 act_rd(0, 1), exp_rd(0, 3'd5), act_rd(0, 2), exp_rd(0, t_r2[0]),
                 act_busy(0), exp_busy(0));
      end
      tick();
      n++;
    end
    t_wr[0] = 1'b0;
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL busy_len got=%0d expected 8", n);
    end
    for (int a = 0; a < 8; a++) begin
      t_r1[0] = 3'(a);
      #1;
      checks++;
      if (act_rd(0, 1) !== 32'h0 || act_busy(0) !== 1'b0) begin
        failures++;
        $display("FAIL after_clear a=%0d rd1=%h busy=%b expected 0/0", a, act_rd(0, 1), act_busy(0));
      end
    end
  endtask

  task automatic test_clear_with_write();
    int n;
    idle_inputs();
    t_wr[0] = 1'b1; t_wa[0] = 3'd3; t_wd[0] = 32'h3C3CA5A5;
    t_cl[0] = 1'b1; t_r1[0] = 3'd3;
    tick();
    t_wr[0] = 1'b0; t_cl[0] = 1'b0;
    #1;
    checks++;
    if (act_rd(0, 1) !== 32'h3C3CA5A5 || act_busy(0) !== 1'b1) begin
      failures++;
      $display("FAIL clear_write_commit rd1=%h busy=%b expected 3c3ca5a5/1", act_rd(0, 1), act_busy(0));
    end
    n = 0;
    while (sw[0] >= 0 && n < 20) begin
      tick();
      n++;
    end
    #1;
    checks++;
    if (act_rd(0, 1) !== 32'h0 || act_busy(0) !== 1'b0) begin
      failures++;
      $display("FAIL clear_write_swept rd1=%h busy=%b expected 0/0", act_rd(0, 1), act_busy(0));
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    for (int a = 0; a < 8; a++) begin
      t_wr[0] = 1'b1; t_wa[0] = 3'(a); t_wd[0] = $urandom | 32'h100;
      tick();
    end
    t_wr[0] = 1'b0;
    t_cl[0] = 1'b1;
    tick();
    t_cl[0] = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (act_busy(0) !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_busy busy=%b expected 1", act_busy(0));
    end
    #2 reset = 1'b1;
    #1 model_reset();
    for (int a = 0; a < 8; a++) begin
      t_r1[0] = 3'(a);
      t_r2[0] = 3'(7 - a);
      #1;
      checks++;
      if (act_rd(0, 1) !== 32'h0 || act_rd(0, 2) !== 32'h0 || act_busy(0) !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_sweep a=%0d rd1=%h rd2=%h busy=%b expected 0/0/0",
                 a, act_rd(0, 1), act_rd(0, 2), act_busy(0));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        t_wr[d] = 1'($urandom_range(0, 1));
        t_wa[d] = 3'($urandom_range(0, dep[d] - 1));
        t_wd[d] = $urandom;
        t_cl[d] = ($urandom_range(0, 23) == 0);
        t_r1[d] = ($urandom_range(0, 2) == 0) ? t_wa[d] : 3'($urandom_range(0, dep[d] - 1));
        t_r2[d] = ($urandom_range(0, 2) == 0) ? t_r1[d] : 3'($urandom_range(0, dep[d] - 1));
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_rd(d, 1) !== exp_rd(d, t_r1[d]) || act_rd(d, 2) !== exp_rd(d, t_r2[d])
            || act_busy(d) !== exp_busy(d)) begin
          failures++;
          $display("FAIL random c=%0d d=%0d rd1=%h/%h rd2=%h/%h busy=%b/%b", c, d,
                   act_rd(d, 1), exp_rd(d, t_r1[d]), act_rd(d, 2), exp_rd(d, t_r2[d]),
                   act_busy(d), exp_busy(d));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12 reset = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bulk_clear();
    test_clear_with_write();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
